// File: rtl/outer_product_mac_if.sv
// Operand/result bus of the 3x3 outer-product multiply-accumulate block.
// The memory stage and the result consumer sit on the master side.
interface outer_product_mac_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10
);
  logic              start;
  logic [DATA_W-1:0] data_w1;
  logic [DATA_W-1:0] data_w2;
  logic [DATA_W-1:0] data_w3;
  logic [DATA_W-1:0] data_x1;
  logic [DATA_W-1:0] data_x2;
  logic [DATA_W-1:0] data_x3;
  logic              unload1;
  logic              unload2;
  logic              unload3;
  logic              busy;
  logic [ACC_W-1:0]  result_data;
  logic [3:0]        result_idx;
  logic              result_valid;
  logic              result_ready;
  logic              done;

  modport slave (
    input  start, data_w1, data_w2, data_w3, data_x1, data_x2, data_x3, result_ready,
    output unload1, unload2, unload3, busy, result_data, result_idx, result_valid, done
  );

  modport master (
    output start, data_w1, data_w2, data_w3, data_x1, data_x2, data_x3, result_ready,
    input  unload1, unload2, unload3, busy, result_data, result_idx, result_valid, done
  );
endinterface

// File: rtl/outer_product_mac.sv
// 3x3 matrix product C = W*X built from three accumulated outer products.
// Step k pulls W column k-1 and X row k-1 from the memory stage through the
// one-hot unload lines, then the nine results drain over a valid/ready port.
// ACC_W must equal 2*DATA_W+2 so that three full-scale products never wrap.
module outer_product_mac #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10
) (
  input  logic               clk,
  input  logic               clear_n,
  outer_product_mac_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              start_prev_q, start_prev_d;
  logic [2:0]        unload_q, unload_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [3:0]        idx_q, idx_d;
  logic [ACC_W-1:0]  data_q, data_d;
  logic [ACC_W-1:0]  acc_q [9];
  logic [ACC_W-1:0]  acc_d [9];

  logic [DATA_W-1:0] w_s [3];
  logic [DATA_W-1:0] x_s [3];
  logic [PROD_W-1:0] prod_s [9];
  logic              start_edge_s;
  logic              accept_s;
  logic              run_start_s;
  logic              stepping_s;

  // Gather the operand buses into indexable arrays and form the nine products.
  always_comb begin
    w_s[0] = bus.data_w1;
    w_s[1] = bus.data_w2;
    w_s[2] = bus.data_w3;
    x_s[0] = bus.data_x1;
    x_s[1] = bus.data_x2;
    x_s[2] = bus.data_x3;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_s[i*3+j] = {{DATA_W{1'b0}}, w_s[i]} * {{DATA_W{1'b0}}, x_s[j]};
      end
    end
  end

  // Sequencer: rising-edge start detect, step/drain/finish progression.
  always_comb begin
    start_edge_s = bus.start & ~start_prev_q;
    accept_s     = valid_q & bus.result_ready;
    start_prev_d = bus.start;
    state_d      = state_q;
    case (state_q)
      IDLE: begin
        if (start_edge_s) begin
          state_d = STEP1;
        end else begin
          state_d = IDLE;
        end
      end
      STEP1: state_d = STEP2;
      STEP2: state_d = STEP3;
      STEP3: state_d = DRAIN;
      DRAIN: begin
        if (accept_s && (idx_q == 4'd8)) begin
          state_d = FIN;
        end else begin
          state_d = DRAIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    run_start_s = (state_q == IDLE) && (state_d == STEP1);
    stepping_s  = (state_q == STEP1) || (state_q == STEP2) || (state_q == STEP3);
  end

  // Accumulators: cleared when a run begins, one outer product per step.
  always_comb begin
    for (int n = 0; n < 9; n++) begin
      if (run_start_s) begin
        acc_d[n] = {ACC_W{1'b0}};
      end else if (stepping_s) begin
        acc_d[n] = acc_q[n] + {{(ACC_W-PROD_W){1'b0}}, prod_s[n]};
      end else begin
        acc_d[n] = acc_q[n];
      end
    end
  end

  // Registered outputs, all derived from the next state so they line up with it.
  always_comb begin
    unload_d[0] = (state_d == STEP1);
    unload_d[1] = (state_d == STEP2);
    unload_d[2] = (state_d == STEP3);
    busy_d      = (state_d != IDLE);
    valid_d     = (state_d == DRAIN);
    done_d      = (state_d == FIN);
    if (state_d == DRAIN) begin
      if (state_q != DRAIN) begin
        idx_d = 4'd0;
      end else if (accept_s) begin
        idx_d = idx_q + 4'd1;
      end else begin
        idx_d = idx_q;
      end
    end else begin
      idx_d = 4'd0;
    end
    if (valid_d && (idx_d < 4'd9)) begin
      data_d = acc_d[idx_d];
    end else begin
      data_d = {ACC_W{1'b0}};
    end
  end

  // State and output flops with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      unload_q     <= 3'b000;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      idx_q        <= 4'd0;
      data_q       <= {ACC_W{1'b0}};
      for (int n = 0; n < 9; n++) begin
        acc_q[n] <= {ACC_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      unload_q     <= unload_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      for (int n = 0; n < 9; n++) begin
        acc_q[n] <= acc_d[n];
      end
    end
  end

  assign bus.unload1      = unload_q[0];
  assign bus.unload2      = unload_q[1];
  assign bus.unload3      = unload_q[2];
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result_idx   = idx_q;
  assign bus.result_data  = data_q;
  assign bus.done         = done_q;

endmodule

// File: doc/outer_product_mac.md
OUTER_PRODUCT_MAC -- requirements
Module: outer_product_mac

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the element width of both operand matrices.
REQ-002 The block SHALL have parameter ACC_W, default 10, giving the accumulator and result width; ACC_W SHALL equal 2*DATA_W+2.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port clear_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 Port start, input, 1, level from the memory stage meaning both matrices are loaded; it can stay high indefinitely.
REQ-006 Ports data_w1/data_w2/data_w3, input, DATA_W each, unsigned W column elements for rows 0/1/2.
REQ-007 Ports data_x1/data_x2/data_x3, input, DATA_W each, unsigned X row elements for columns 0/1/2.
REQ-008 Ports unload1/unload2/unload3, output, 1 each, registered one-hot selects for operand step k (W column k-1, X row k-1).
REQ-009 Port busy, output, 1, high in every state except IDLE.
REQ-010 Port result_data, output, ACC_W, the C element being offered.
REQ-011 Port result_idx, output, 4, row-major index 0..8 of result_data (i*3+j).
REQ-012 Port result_valid, output, 1, meaning a result is offered.
REQ-013 Port result_ready, input, 1, the consumer's accept.
REQ-014 Port done, output, 1, a one-cycle pulse after the last result is accepted.

Function
REQ-015 The block SHALL compute C = W*X for 3x3 matrices as three accumulated outer products, with C[i][j] += w_(i+1)*x_(j+1) at step k.
REQ-016 The FSM SHALL have the states IDLE, STEP1, STEP2, STEP3, DRAIN and FIN.
- IDLE -> STEP1 when start=1 and start_d=0, where start_d is start registered and reset to 0.
- STEP1 -> STEP2 -> STEP3 -> DRAIN, one cycle each.
- DRAIN -> FIN when index 8 is accepted.
- FIN -> IDLE after one cycle.
REQ-017 On the IDLE->STEP1 edge, all nine accumulators SHALL clear to 0.
REQ-018 unloadk SHALL be high only during STEPk; at most one unload line SHALL be high in any cycle.
REQ-019 Each accumulator SHALL sample the data inputs at the clock edge that ends STEPk, while unloadk is high, and add the unsigned product zero-extended to ACC_W.
REQ-020 Accumulation SHALL NOT overflow: the worst case is 3*(2^DATA_W-1)^2 = 675 for the defaults.
REQ-021 In DRAIN, result_valid SHALL be 1, with result_idx starting at 0 on DRAIN entry and result_data equal to C[result_idx].
REQ-022 The index SHALL advance by 1 on each cycle where result_valid and result_ready are both 1.
REQ-023 result_data and result_idx SHALL hold stable while result_valid=1 and result_ready=0, for any number of cycles.
REQ-024 result_valid SHALL be 0 outside DRAIN; done SHALL be 1 only in FIN.
REQ-025 Latency: with result_ready held at 1, the first result SHALL appear 3 cycles after the start rising edge is sampled, and done SHALL pulse 9 cycles after that.
REQ-026 A start rising edge, or start held high, while busy=1 SHALL be ignored.
REQ-027 A new run SHALL require start to return to 0 and rise again.
REQ-028 A start that is already high at reset release SHALL count as a rising edge.
REQ-029 The accumulators SHALL retain C after FIN until the next run begins.

Reset
REQ-030 When clear_n=0, the block SHALL asynchronously force:
- state to IDLE;
- start_d, unload1..3, busy, result_valid and done to 0;
- result_idx, result_data and all accumulators to 0.
REQ-031 Assertion of clear_n mid-run, in any STEP or in DRAIN, SHALL abort the run with no further result or done.
REQ-032 After clear_n deasserts, the next run SHALL need a start rising edge, or start high at release per REQ-028.

Verification
REQ-033 Scenario 1: W = X = 1..9 row-major, start rises, ready=1 -> results 30,36,42,66,81,96,102,126,150 at idx 0..8, then done pulses once.
REQ-034 Scenario 2: all elements 15 -> every result is 675 with no wrap.
REQ-035 Scenario 3: ready toggled 1-0-0-1 per cycle -> data and idx hold while stalled, and each index is delivered exactly once in order.
REQ-036 Scenario 4: start held high through FIN and beyond -> no second run; drop start, then raise it -> a second identical run follows, with accumulators re-cleared.
REQ-037 Scenario 5: clear_n pulsed low during STEP2, and separately at idx 4 in DRAIN -> all outputs 0 immediately, and no done pulse.
REQ-038 Scenario 6: in every cycle of every test -> the unload lines are one-hot or all-zero, and high only in STEP1..3.
